// File: rtl/wb_commit_monitor.sv
`timescale 1ns/1ps
// Purpose : watches the MIPS writeback stage and fetch PC, logs every register commit with a
//           cycle stamp into a show-ahead trace FIFO and reports halt (PC match) or hang (timeout).
// Latency : a commit seen on one edge is visible at the FIFO head one cycle later;
//           State changes on the edge after the halt/hang condition.
// Backpr. : the core is never stalled; a commit arriving while the FIFO is full with no pop in the
//           same cycle is dropped and the sticky Overflow flag is set.
// Ports   : Clk/Reset (sync, active-high); Enable starts a run; HaltPC/PCOutF detect program end;
//           RegWriteW/WriteRegW/WriteDataW are the observed commit; TraceRdEn pops the head;
//           Trace* expose the head entry and fill level; Overflow/CommitCount/CycleCount/State/Done
//           report status.
module wb_commit_monitor #(
   parameter int DATA_W    = 32,
   parameter int REG_W     = 5,
   parameter int DEPTH     = 16,
   parameter int CYC_W     = 16,
   parameter int TIMEOUT   = 64,
   parameter int RECORD_R0 = 0
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Enable,
   input  logic [DATA_W-1:0]         HaltPC,
   input  logic [DATA_W-1:0]         PCOutF,
   input  logic                      RegWriteW,
   input  logic [REG_W-1:0]          WriteRegW,
   input  logic [DATA_W-1:0]         WriteDataW,
   input  logic                      TraceRdEn,
   output logic                      TraceValid,
   output logic [REG_W-1:0]          TraceReg,
   output logic [DATA_W-1:0]         TraceData,
   output logic [CYC_W-1:0]          TraceCycle,
   output logic [$clog2(DEPTH):0]    TraceCount,
   output logic                      Overflow,
   output logic [CYC_W-1:0]          CommitCount,
   output logic [CYC_W-1:0]          CycleCount,
   output logic [1:0]                State,
   output logic                      Done
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [CYC_W-1:0] IDLE_LIMIT = CYC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      HUNG   = 2'd3
   } state_t;

   state_t state, nextState;

   logic [REG_W-1:0]  regMem  [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [CYC_W-1:0]  cycMem  [DEPTH];

   logic [AW-1:0]    wrPtr, rdPtr;
   logic [CNT_W-1:0] count;
   logic [CYC_W-1:0] cycleCnt, commitCnt, idleCnt;
   logic             overflowFlag;

   logic validCommit, capture, empty, full, pop, push, drop;

   always_comb begin
      validCommit = RegWriteW && ((WriteRegW != '0) || (RECORD_R0 != 0));
      capture     = (state == RUN) && validCommit;
      empty       = (count == '0);
      full        = (count == FULL_CNT);
      pop         = TraceRdEn && !empty;
      // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
      push        = capture && (!full || pop);
      drop        = capture && full && !pop;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (Enable) nextState = RUN;
         RUN: begin
            // Halt wins over hang when both fire together.
            if (PCOutF == HaltPC)
               nextState = HALTED;
            else if (!validCommit && (idleCnt == IDLE_LIMIT))
               nextState = HUNG;
         end
         default: nextState = state;
      endcase
   end

   // ---------------- trace storage (no reset needed; head is gated by TraceValid) ----------------
   always_ff @(posedge Clk) begin
      if (!Reset && push) begin
         regMem[wrPtr]  <= WriteRegW;
         dataMem[wrPtr] <= WriteDataW;
         cycMem[wrPtr]  <= cycleCnt;
      end
   end

   // ---------------- pointers, counters, flags ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wrPtr        <= '0;
         rdPtr        <= '0;
         count        <= '0;
         overflowFlag <= 1'b0;
         commitCnt    <= '0;
         cycleCnt     <= '0;
         idleCnt      <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + AW'(1);
            if (commitCnt != '1) commitCnt <= commitCnt + CYC_W'(1);
         end
         if (pop) rdPtr <= rdPtr + AW'(1);

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (drop) overflowFlag <= 1'b1;

         if (state == RUN) begin
            if (cycleCnt != '1) cycleCnt <= cycleCnt + CYC_W'(1);
            // Any valid commit restarts the hang window, even one that gets dropped.
            if (validCommit)
               idleCnt <= '0;
            else if (idleCnt != '1)
               idleCnt <= idleCnt + CYC_W'(1);
         end
      end
   end

   // ---------------- outputs ----------------
   assign TraceValid  = !empty;
   assign TraceReg    = empty ? '0 : regMem[rdPtr];
   assign TraceData   = empty ? '0 : dataMem[rdPtr];
   assign TraceCycle  = empty ? '0 : cycMem[rdPtr];
   assign TraceCount  = count;
   assign Overflow    = overflowFlag;
   assign CommitCount = commitCnt;
   assign CycleCount  = cycleCnt;
   assign State       = state;
   assign Done        = (state == HALTED) || (state == HUNG);

endmodule

// File: tb/tb_wb_commit_monitor.sv
`timescale 1ns/1ps
// Directed bench for wb_commit_monitor: capture/filter, halt, hang, overflow, full push+pop, reset.
module tb_wb_commit_monitor;

   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int DEPTH   = 16;
   localparam int CYC_W   = 16;
   localparam int TIMEOUT = 64;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Enable;
   logic [DATA_W-1:0] HaltPC;
   logic [DATA_W-1:0] PCOutF;
   logic              RegWriteW;
   logic [REG_W-1:0]  WriteRegW;
   logic [DATA_W-1:0] WriteDataW;
   logic              TraceRdEn;
   logic              TraceValid;
   logic [REG_W-1:0]  TraceReg;
   logic [DATA_W-1:0] TraceData;
   logic [CYC_W-1:0]  TraceCycle;
   logic [$clog2(DEPTH):0] TraceCount;
   logic              Overflow;
   logic [CYC_W-1:0]  CommitCount;
   logic [CYC_W-1:0]  CycleCount;
   logic [1:0]        State;
   logic              Done;

   int passCnt  = 0;
   int totalCnt = 0;

   always #5 Clk = ~Clk;

   wb_commit_monitor #(
      .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CYC_W(CYC_W),
      .TIMEOUT(TIMEOUT), .RECORD_R0(0)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .HaltPC(HaltPC), .PCOutF(PCOutF),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .WriteDataW(WriteDataW),
      .TraceRdEn(TraceRdEn), .TraceValid(TraceValid), .TraceReg(TraceReg),
      .TraceData(TraceData), .TraceCycle(TraceCycle), .TraceCount(TraceCount),
      .Overflow(Overflow), .CommitCount(CommitCount), .CycleCount(CycleCount),
      .State(State), .Done(Done)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic checkHead(input string tag, input int r, input int d, input int c);
      check({tag, "_valid"}, 64'(TraceValid), 64'(1));
      check({tag, "_reg"},   64'(TraceReg),   64'(r));
      check({tag, "_data"},  64'(TraceData),  64'(d));
      check({tag, "_cycle"}, 64'(TraceCycle), 64'(c));
   endtask

   task automatic commit(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
      RegWriteW  = 1'b1;
      WriteRegW  = r;
      WriteDataW = d;
   endtask

   task automatic noCommit();
      RegWriteW = 1'b0;
   endtask

   task automatic popOne();
      TraceRdEn = 1'b1;
      tick();
      TraceRdEn = 1'b0;
   endtask

   // Reset, then Enable; returns on the first cycle in RUN.
   task automatic startRun();
      Reset = 1'b1;
      tick();
      Reset  = 1'b0;
      Enable = 1'b1;
      tick();
      Enable = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Enable = 1'b0; HaltPC = 32'h40; PCOutF = 32'h0;
      RegWriteW = 1'b0; WriteRegW = '0; WriteDataW = '0; TraceRdEn = 1'b0;
      ticks(2);

      // ---- reset state ----
      check("rst_state",   64'(State),       64'(0));
      check("rst_valid",   64'(TraceValid),  64'(0));
      check("rst_count",   64'(TraceCount),  64'(0));
      check("rst_ovf",     64'(Overflow),    64'(0));
      check("rst_commits", 64'(CommitCount), 64'(0));
      check("rst_cycles",  64'(CycleCount),  64'(0));
      check("rst_done",    64'(Done),        64'(0));
      check("rst_reg",     64'(TraceReg),    64'(0));
      check("rst_data",    64'(TraceData),   64'(0));
      check("rst_cyc",     64'(TraceCycle),  64'(0));

      // ---- basic capture, r0 filtering, Enable drop in RUN ----
      Reset = 1'b0; Enable = 1'b1;
      tick();
      check("enter_run", 64'(State), 64'(1));
      Enable = 1'b0;
      commit(5'd8, 32'd5); tick();
      commit(5'd9, 32'd7); tick();
      commit(5'd0, 32'd3); tick();
      noCommit();
      check("basic_count",   64'(TraceCount),  64'(2));
      check("basic_commits", 64'(CommitCount), 64'(2));
      check("basic_state",   64'(State),       64'(1));
      check("basic_cycles",  64'(CycleCount),  64'(3));
      checkHead("pop0", 8, 5, 0);
      popOne();
      checkHead("pop1", 9, 7, 1);
      check("pop1_count", 64'(TraceCount), 64'(1));
      popOne();
      check("pop2_valid", 64'(TraceValid), 64'(0));
      check("pop2_count", 64'(TraceCount), 64'(0));
      check("pre_halt_cycles", 64'(CycleCount), 64'(5));

      // ---- halt with a commit in the same cycle ----
      PCOutF = 32'h40; commit(5'd2, 32'd1);
      tick();
      noCommit(); PCOutF = 32'h0;
      check("halt_state",  64'(State),      64'(2));
      check("halt_done",   64'(Done),       64'(1));
      check("halt_count",  64'(TraceCount), 64'(1));
      check("halt_cycles", 64'(CycleCount), 64'(6));
      checkHead("halt_head", 2, 1, 5);
      Enable = 1'b1; commit(5'd3, 32'h33);
      ticks(3);
      noCommit(); Enable = 1'b0;
      check("halted_state",   64'(State),       64'(2));
      check("halted_cycles",  64'(CycleCount),  64'(6));
      check("halted_count",   64'(TraceCount),  64'(1));
      check("halted_commits", 64'(CommitCount), 64'(3));
      popOne();
      check("halted_drain", 64'(TraceValid), 64'(0));

      // ---- hang after exactly TIMEOUT idle cycles ----
      startRun();
      ticks(63);
      check("hang_pre",    64'(State),      64'(1));
      tick();
      check("hang_state",  64'(State),      64'(3));
      check("hang_done",   64'(Done),       64'(1));
      check("hang_cycles", 64'(CycleCount), 64'(64));

      // ---- a commit at cycle 63 restarts the window ----
      startRun();
      ticks(63);
      commit(5'd5, 32'd9);
      tick();
      noCommit();
      check("restart_state", 64'(State),       64'(1));
      check("restart_cnt",   64'(CommitCount), 64'(1));
      checkHead("restart_head", 5, 9, 63);
      ticks(63);
      check("restart_pre",  64'(State), 64'(1));
      tick();
      check("restart_hung",   64'(State),      64'(3));
      check("restart_cycles", 64'(CycleCount), 64'(128));

      // ---- halt beats hang in the same cycle ----
      startRun();
      ticks(63);
      PCOutF = 32'h40;
      tick();
      PCOutF = 32'h0;
      check("halt_over_hang", 64'(State), 64'(2));

      // ---- overflow: 20 commits into 16 slots ----
      startRun();
      for (int k = 0; k < 20; k++) begin
         commit(5'(k + 1), 32'('h100 + k));
         tick();
      end
      noCommit();
      check("ovf_count",   64'(TraceCount),  64'(16));
      check("ovf_flag",    64'(Overflow),    64'(1));
      check("ovf_commits", 64'(CommitCount), 64'(16));
      for (int k = 0; k < 16; k++) begin
         checkHead($sformatf("ovf_e%0d", k), k + 1, 'h100 + k, k);
         popOne();
      end
      check("ovf_empty", 64'(TraceValid), 64'(0));
      popOne();
      check("empty_pop_count", 64'(TraceCount), 64'(0));
      check("ovf_sticky",      64'(Overflow),   64'(1));

      // ---- full FIFO: simultaneous push and pop ----
      startRun();
      check("rst_clears_ovf", 64'(Overflow), 64'(0));
      for (int k = 0; k < 16; k++) begin
         commit(5'(k + 1), 32'('h200 + k));
         tick();
      end
      commit(5'd31, 32'hABC); TraceRdEn = 1'b1;
      tick();
      TraceRdEn = 1'b0; noCommit();
      check("full_pp_count",   64'(TraceCount),  64'(16));
      check("full_pp_ovf",     64'(Overflow),    64'(0));
      check("full_pp_commits", 64'(CommitCount), 64'(17));
      for (int k = 1; k < 16; k++) begin
         check($sformatf("full_pp_d%0d", k), 64'(TraceData),  64'('h200 + k));
         check($sformatf("full_pp_c%0d", k), 64'(TraceCycle), 64'(k));
         popOne();
      end
      checkHead("full_pp_last", 31, 'hABC, 16);
      popOne();
      check("full_pp_empty", 64'(TraceValid), 64'(0));

      // ---- reset mid-run discards queued entries ----
      startRun();
      for (int k = 0; k < 5; k++) begin
         commit(5'(k + 10), 32'(k));
         tick();
      end
      noCommit();
      check("mid_count", 64'(TraceCount), 64'(5));
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_state",   64'(State),       64'(0));
      check("mid_tcount",  64'(TraceCount),  64'(0));
      check("mid_valid",   64'(TraceValid),  64'(0));
      check("mid_commits", 64'(CommitCount), 64'(0));
      check("mid_cycles",  64'(CycleCount),  64'(0));
      check("mid_data",    64'(TraceData),   64'(0));
      popOne();
      check("mid_pop_count", 64'(TraceCount), 64'(0));
      check("mid_pop_valid", 64'(TraceValid), 64'(0));
      check("mid_pop_state", 64'(State),      64'(0));

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
